eth_tx_scheduler: RTL

Byte-stream scheduler that feeds the RGMII transmit serializer. It arbitrates between two frame sources round-robin and frames each payload with preamble and SFD. It enforces the inter-frame gap and generates the `data_enable` strobe at the byte rate for 10/100/1000 Mb/s operation. Outputs connect directly to the serializer's `data`, `data_valid`, `data_enable` and `data_error` inputs, all in the 125 MHz `clk` domain.

---
 rtl/eth_tx_scheduler.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/eth_tx_scheduler.sv
// Two-source round-robin transmit scheduler for an RGMII serializer: adds preamble/SFD,
// enforces the inter-frame gap and paces bytes with a speed-dependent strobe.
module eth_tx_scheduler #(
  parameter int IFG_BYTES      = 12,
  parameter int PREAMBLE_BYTES = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] speed,
  input  logic       req0,
  input  logic       req1,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic       last0,
  input  logic       last1,
  input  logic       err0,
  input  logic       err1,
  output logic       rd0,
  output logic       rd1,
  output logic       grant,
  output logic       busy,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       data_enable,
  output logic       data_error
);
  localparam int CMAX = (IFG_BYTES > PREAMBLE_BYTES) ? IFG_BYTES : PREAMBLE_BYTES;
  localparam int CW   = $clog2(CMAX) + 1;

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, IFG} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [6:0]    per, tcnt, p_sel;
  logic          tick, spd_chg, pick;
  logic          lastg, lastg_n, grant_n, busy_n;
  logic [7:0]    data_n;
  logic          valid_n, err_n, de_n;
  logic [1:0]    rd_q, rd_n;
  logic [1:0]    sreq, slast, serr;
  logic [1:0][7:0] sdata;

  assign sreq  = {req1, req0};
  assign slast = {last1, last0};
  assign serr  = {err1, err0};
  assign sdata = {data1, data0};
  assign rd0   = rd_q[0];
  assign rd1   = rd_q[1];

  always_comb begin
    case (speed)
      2'b00:   p_sel = 7'd100;
      2'b01:   p_sel = 7'd10;
      default: p_sel = 7'd1;
    endcase
  end

  // A new period is only adopted between frames; the changeover cycle never ticks.
  assign spd_chg = (state == IDLE) && (p_sel != per);
  assign tick    = !spd_chg && (tcnt == per - 7'd1);
  assign pick    = (sreq[0] && sreq[1]) ? ~lastg : sreq[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per  <= 7'd1;
      tcnt <= '0;
    end else if (spd_chg) begin
      per  <= p_sel;
      tcnt <= '0;
    end else if (tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 7'd1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    lastg_n = lastg;
    grant_n = grant;
    data_n  = data;
    valid_n = data_valid;
    err_n   = data_error;
    de_n    = 1'b0;
    rd_n    = 2'b00;
    busy_n  = busy;
    if (state == IDLE) busy_n = 1'b0;
    if (tick) begin
      de_n    = 1'b1;
      data_n  = 8'h00;
      valid_n = 1'b0;
      err_n   = 1'b0;
      if (state != IDLE) busy_n = 1'b1;
      case (state)
        IDLE: if (|sreq) begin
          grant_n = pick;
          lastg_n = pick;
          cnt_n   = '0;
          state_n = PRE;
        end
        PRE: begin
          data_n  = 8'h55;
          valid_n = 1'b1;
          if (cnt == CW'(PREAMBLE_BYTES - 1)) begin
            cnt_n   = '0;
            state_n = SFD;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        SFD: begin
          data_n  = 8'hD5;
          valid_n = 1'b1;
          state_n = DATA;
        end
        DATA: begin
          valid_n = 1'b1;
          if (!sreq[grant]) begin
            // Source withdrew mid-frame: poison the frame and close it out.
            err_n   = 1'b1;
            cnt_n   = '0;
            state_n = IFG;
          end else begin
            data_n      = sdata[grant];
            err_n       = serr[grant];
            rd_n[grant] = 1'b1;
            if (slast[grant]) begin
              cnt_n   = '0;
              state_n = IFG;
            end
          end
        end
        IFG: begin
          if (cnt == CW'(IFG_BYTES - 1)) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lastg       <= 1'b1;
      grant       <= 1'b0;
      busy        <= 1'b0;
      data        <= 8'h00;
      data_valid  <= 1'b0;
      data_error  <= 1'b0;
      data_enable <= 1'b0;
      rd_q        <= 2'b00;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      lastg       <= lastg_n;
      grant       <= grant_n;
      busy        <= busy_n;
      data        <= data_n;
      data_valid  <= valid_n;
      data_error  <= err_n;
      data_enable <= de_n;
      rd_q        <= rd_n;
    end
  end
endmodule
